resource_pool_alloc: RTL

- Parametrised multi-channel pointer allocator for the WQE resource pool. It supersedes the single-channel bitmap allocator.
- A background scanner walks the pool and prefetches free indices into a small FIFO.
- NUM_CH requesters are served round-robin through one registered allocate stream. Each grant carries a channel tag.
- Releases are checked against an allocated-bitmap, so double-frees and out-of-range frees are flagged and dropped instead of corrupting state.

---
 rtl/resource_pool_alloc_pkg.sv | 24 ++
 rtl/resource_pool_alloc_if.sv | 46 ++++
 rtl/resource_pool_alloc_arb.sv | 47 ++++
 rtl/syn_fifo.sv | 41 ++++
 rtl/resource_pool_alloc.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/resource_pool_alloc_pkg.sv
// Shared definitions for the resource pool allocator: default sizes,
// reset level, channel-tag width helper and the scanner action encoding.
// Optional feature macro: RESOURCE_POOL_LOWMARK_EN (see resource_pool_alloc.sv).
package resource_pool_alloc_pkg;

  localparam int unsigned DEF_PTR_WIDTH = 11;
  localparam int unsigned DEF_POOL_SIZE = 1024;

  localparam logic RST_ACTIVE = 1'b0;
  localparam logic FLAG_SET   = 1'b1;
  localparam logic FLAG_CLR   = 1'b0;

  typedef enum logic [1:0] {
    SCAN_HOLD = 2'd0,
    SCAN_PUSH = 2'd1,
    SCAN_SKIP = 2'd2
  } scan_act_e;

  // Channel tag width, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/resource_pool_alloc_if.sv
// Request, release and allocate streams plus status of the resource pool.
interface resource_pool_alloc_if #(
  parameter int unsigned PTR_WIDTH = 11,
  parameter int unsigned ID_WIDTH  = 10,
  parameter int unsigned NUM_CH    = 2
) ();
  import resource_pool_alloc_pkg::*;

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0]          s_axis_apply_valid;
  logic [NUM_CH*ID_WIDTH-1:0] s_axis_apply_id;
  logic [NUM_CH-1:0]          s_axis_apply_ready;
  logic                       s_axis_release_valid;
  logic [PTR_WIDTH-1:0]       s_axis_release_ptr;
  logic                       s_axis_release_ready;
  logic                       m_axis_alloc_valid;
  logic [CH_W-1:0]            m_axis_alloc_ch;
  logic [ID_WIDTH-1:0]        m_axis_alloc_id;
  logic [PTR_WIDTH-1:0]       m_axis_alloc_ptr;
  logic                       m_axis_alloc_ready;
  logic [PTR_WIDTH:0]         free_cnt;
  logic                       release_err;
  logic                       pool_low;

  modport slave (
    input  s_axis_apply_valid, s_axis_apply_id,
    output s_axis_apply_ready,
    input  s_axis_release_valid, s_axis_release_ptr,
    output s_axis_release_ready,
    output m_axis_alloc_valid, m_axis_alloc_ch, m_axis_alloc_id, m_axis_alloc_ptr,
    input  m_axis_alloc_ready,
    output free_cnt, release_err, pool_low
  );

  modport master (
    output s_axis_apply_valid, s_axis_apply_id,
    input  s_axis_apply_ready,
    output s_axis_release_valid, s_axis_release_ptr,
    input  s_axis_release_ready,
    input  m_axis_alloc_valid, m_axis_alloc_ch, m_axis_alloc_id, m_axis_alloc_ptr,
    output m_axis_alloc_ready,
    input  free_cnt, release_err, pool_low
  );

endinterface

// File: rtl/resource_pool_alloc_arb.sv
// Round-robin arbiter: search starts at rr_ptr, which moves past each winner.
module rp_rr_arbiter
  import resource_pool_alloc_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  localparam int unsigned CH_W  = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_any
);
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] rr_nxt;
  int unsigned     pos;

  // Pick the first requester at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      pos = k + 32'(rr_ptr);
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (en && !gnt_any && req[c] && (c == pos)) begin
          gnt[c]  = 1'b1;
          gnt_idx = CH_W'(c);
          gnt_any = 1'b1;
        end
      end
    end
    if (gnt_idx == CH_W'(NUM_CH - 1)) rr_nxt = '0;
    else                              rr_nxt = gnt_idx + CH_W'(1);
  end

  // Priority pointer advances only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ACTIVE) rr_ptr <= '0;
    else if (gnt_any)        rr_ptr <= rr_nxt;
  end

endmodule

// File: rtl/syn_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
module syn_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array, no reset needed: contents are only read below wr_ptr.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read/write pointers with wrap bit for full/empty distinction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/resource_pool_alloc.sv
// Multi-channel pointer allocator for the WQE resource pool.
// A scanner prefetches free indices into a small FIFO; requesters are
// served round-robin through one registered allocate stream; releases
// are validated against the allocated bitmap.
// Optional feature: define RESOURCE_POOL_LOWMARK_EN to drive pool_low
// from the free count against LOW_MARK; otherwise pool_low is tied 0.
module resource_pool_alloc
  import resource_pool_alloc_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int unsigned POOL_SIZE = DEF_POOL_SIZE,
  parameter int unsigned ID_WIDTH  = 10,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned PF_DEPTH  = 16,
  parameter int unsigned LOW_MARK  = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  resource_pool_alloc_if.slave bus
);
  localparam int unsigned CH_W = ch_width(NUM_CH);

  if (((64'd1 << PTR_WIDTH) < 64'(POOL_SIZE)) || (POOL_SIZE < 2) ||
      (NUM_CH < 1) || (NUM_CH > 8) || (LOW_MARK > POOL_SIZE)) begin : g_bad_cfg
    $error("resource_pool_alloc: inconsistent parameters");
  end

  logic [POOL_SIZE-1:0] rsv, rsv_nxt;   // entry sits in the prefetch FIFO
  logic [POOL_SIZE-1:0] alc, alc_nxt;   // entry is owned by a consumer
  logic [PTR_WIDTH-1:0] scan_ptr, scan_ptr_nxt;
  logic [PTR_WIDTH-1:0] head;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  scan_act_e            scan_act;
  logic                 scan_taken;
  logic                 rel_ok;
  logic                 adv;
  logic [NUM_CH-1:0]    gnt;
  logic [CH_W-1:0]      gnt_idx;
  logic                 gnt_any;
  logic [ID_WIDTH-1:0]  id_sel;
  logic [PTR_WIDTH:0]   free_cnt_q, free_cnt_nxt;

  logic                 alloc_valid_q;
  logic [CH_W-1:0]      alloc_ch_q;
  logic [ID_WIDTH-1:0]  alloc_id_q;
  logic [PTR_WIDTH-1:0] alloc_ptr_q;
  logic                 release_err_q;
  logic                 release_ready_q;

  assign adv = !alloc_valid_q || bus.m_axis_alloc_ready;
  assign pop = gnt_any;

  syn_fifo #(
    .DATA_WIDTH(PTR_WIDTH),
    .RAM_DEPTH (PF_DEPTH)
  ) u_pf_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .wr_en  (push),
    .wr_data(scan_ptr),
    .rd_en  (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  rp_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .req    (bus.s_axis_apply_valid),
    .en     (adv && !fifo_empty),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );

  // Scanner: push a free entry, skip a taken one, hold while the FIFO is full.
  always_comb begin
    scan_taken = 1'b0;
    for (int unsigned i = 0; i < POOL_SIZE; i++) begin
      if (scan_ptr == PTR_WIDTH'(i)) scan_taken = rsv[i] | alc[i];
    end
    if (scan_taken)      scan_act = SCAN_SKIP;
    else if (!fifo_full) scan_act = SCAN_PUSH;
    else                 scan_act = SCAN_HOLD;
    push = (scan_act == SCAN_PUSH);
    scan_ptr_nxt = scan_ptr;
    if (scan_act != SCAN_HOLD) begin
      if (scan_ptr == PTR_WIDTH'(POOL_SIZE - 1)) scan_ptr_nxt = '0;
      else                                       scan_ptr_nxt = scan_ptr + PTR_WIDTH'(1);
    end
  end

  // Release validation and bitmap update; the decoded compares also
  // reject out-of-range pointers since no entry matches them.
  always_comb begin
    rel_ok  = 1'b0;
    rsv_nxt = rsv;
    alc_nxt = alc;
    for (int unsigned i = 0; i < POOL_SIZE; i++) begin
      if (bus.s_axis_release_valid && (bus.s_axis_release_ptr == PTR_WIDTH'(i)) && alc[i])
        rel_ok = 1'b1;
    end
    for (int unsigned i = 0; i < POOL_SIZE; i++) begin
      if (push && (scan_ptr == PTR_WIDTH'(i))) rsv_nxt[i] = FLAG_SET;
      if (pop && (head == PTR_WIDTH'(i))) begin
        rsv_nxt[i] = FLAG_CLR;
        alc_nxt[i] = FLAG_SET;
      end
      if (rel_ok && (bus.s_axis_release_ptr == PTR_WIDTH'(i))) alc_nxt[i] = FLAG_CLR;
    end
  end

  // Tag of the winning channel and next free count.
  always_comb begin
    id_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) id_sel = bus.s_axis_apply_id[c*ID_WIDTH +: ID_WIDTH];
    end
    unique case ({pop, rel_ok})
      2'b10:   free_cnt_nxt = free_cnt_q - (PTR_WIDTH+1)'(1);
      2'b01:   free_cnt_nxt = free_cnt_q + (PTR_WIDTH+1)'(1);
      default: free_cnt_nxt = free_cnt_q;
    endcase
  end

  // Pool state: bitmaps, scan position, free count, release status.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (sys_rst_n == RST_ACTIVE) begin
      rsv             <= '0;
      alc             <= '0;
      scan_ptr        <= '0;
      free_cnt_q      <= (PTR_WIDTH+1)'(POOL_SIZE);
      release_err_q   <= 1'b0;
      release_ready_q <= 1'b0;
    end else begin
      rsv             <= rsv_nxt;
      alc             <= alc_nxt;
      scan_ptr        <= scan_ptr_nxt;
      free_cnt_q      <= free_cnt_nxt;
      release_err_q   <= bus.s_axis_release_valid && !rel_ok;
      release_ready_q <= 1'b1;
    end
  end

  // Allocate output register: load on grant, drop when advancing idle, hold otherwise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (sys_rst_n == RST_ACTIVE) begin
      alloc_valid_q <= 1'b0;
      alloc_ch_q    <= '0;
      alloc_id_q    <= '0;
      alloc_ptr_q   <= '0;
    end else if (adv) begin
      alloc_valid_q <= gnt_any;
      if (gnt_any) begin
        alloc_ch_q  <= gnt_idx;
        alloc_id_q  <= id_sel;
        alloc_ptr_q <= head;
      end
    end
  end

`ifdef RESOURCE_POOL_LOWMARK_EN
  localparam logic [PTR_WIDTH:0] LOW_LVL = (PTR_WIDTH+1)'(LOW_MARK);
  logic pool_low_q;

  // Low-watermark flag tracks the count being registered this cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (sys_rst_n == RST_ACTIVE) pool_low_q <= 1'b0;
    else                         pool_low_q <= (free_cnt_nxt <= LOW_LVL);
  end
  assign bus.pool_low = pool_low_q;
`else
  assign bus.pool_low = 1'b0;
`endif

  assign bus.s_axis_apply_ready   = gnt;
  assign bus.s_axis_release_ready = release_ready_q;
  assign bus.m_axis_alloc_valid   = alloc_valid_q;
  assign bus.m_axis_alloc_ch      = alloc_ch_q;
  assign bus.m_axis_alloc_id      = alloc_id_q;
  assign bus.m_axis_alloc_ptr     = alloc_ptr_q;
  assign bus.free_cnt             = free_cnt_q;
  assign bus.release_err          = release_err_q;

endmodule
